// File: rtl/port_alloc_pkg.sv
// Shared sizing and port-index constants for the switch allocator.
package port_alloc_pkg;

    localparam int NUM_CHANNEL  = 5;
    localparam int LOG_NUM_PORT = 3;

    typedef enum logic [LOG_NUM_PORT-1:0] {
        PORT_W      = 3'd0,
        PORT_E      = 3'd1,
        PORT_S      = 3'd2,
        PORT_N      = 3'd3,
        PORT_BYPASS = 3'd4
    } port_e;

endpackage

// File: rtl/port_alloc_rr_arbiter.sv
// Per-output round-robin arbiter: combinational, search starts at ptr and wraps.
// next_ptr is winner+1 (explicit wrap to 0), or ptr itself when nothing is granted.
module rr_arbiter
    import port_alloc_pkg::*;
#(
    parameter int N  = NUM_CHANNEL,
    parameter int LW = LOG_NUM_PORT
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [LW-1:0] next_ptr
);

    logic found;

    // Two passes: [ptr, N-1] first, then the wrapped range [0, ptr-1].
    always_comb begin
        gnt      = '0;
        next_ptr = ptr;
        found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && en && req[i] && (i >= int'(ptr))) begin
                found    = 1'b1;
                gnt[i]   = 1'b1;
                next_ptr = (i == N - 1) ? '0 : LW'(i + 1);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && en && req[i] && (i < int'(ptr))) begin
                found    = 1'b1;
                gnt[i]   = 1'b1;
                next_ptr = (i == N - 1) ? '0 : LW'(i + 1);
            end
        end
    end

endmodule

// File: rtl/port_alloc.sv
// Registered separable switch allocator, 1-cycle latency, stateless requests (losers re-present).
// Define ALLOC_DEFLECT_EN to deflect unmatched valid inputs onto free outputs in ascending order.
module port_alloc
    import port_alloc_pkg::*;
#(
    parameter int NUM_CHANNEL  = port_alloc_pkg::NUM_CHANNEL,
    parameter int LOG_NUM_PORT = port_alloc_pkg::LOG_NUM_PORT
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_CHANNEL-1:0]             req_valid,
    input  logic [NUM_CHANNEL*NUM_CHANNEL-1:0] req_port,
    input  logic [NUM_CHANNEL-1:0]             port_avail,
    output logic [NUM_CHANNEL*NUM_CHANNEL-1:0] alloc_vector,
    output logic [NUM_CHANNEL-1:0]             grant,
    output logic                               alloc_valid
);

    localparam int N = NUM_CHANNEL;

    logic [N-1:0]            eff_req [N];
    logic [N-1:0]            sel     [N];
    logic [N-1:0]            col_req [N];
    logic [N-1:0]            col_gnt [N];
    logic [N-1:0]            row_nxt [N];
    logic [LOG_NUM_PORT-1:0] rr_ptr  [N];
    logic [LOG_NUM_PORT-1:0] rr_nxt  [N];
    logic [N*N-1:0]          vec_nxt;
    logic [N-1:0]            gnt_nxt;
`ifdef ALLOC_DEFLECT_EN
    logic [N-1:0]            free_port;
    logic                    taken;
`endif

    // Stage 1: each input keeps only its highest-index available productive port.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            eff_req[j] = req_valid[j] ? (req_port[j*N +: N] & port_avail) : '0;
            sel[j]     = '0;
            for (int o = 0; o < N; o++) begin
                if (eff_req[j][o]) begin
                    sel[j]    = '0;
                    sel[j][o] = 1'b1;
                end
            end
        end
        for (int o = 0; o < N; o++) begin
            for (int j = 0; j < N; j++) begin
                col_req[o][j] = sel[j][o];
            end
        end
    end

    for (genvar o = 0; o < N; o++) begin : g_arb
        rr_arbiter #(
            .N  (N),
            .LW (LOG_NUM_PORT)
        ) u_arb (
            .req      (col_req[o]),
            .ptr      (rr_ptr[o]),
            .en       (port_avail[o]),
            .gnt      (col_gnt[o]),
            .next_ptr (rr_nxt[o])
        );
    end

    always_comb begin
        for (int j = 0; j < N; j++) begin
            for (int o = 0; o < N; o++) begin
                row_nxt[j][o] = col_gnt[o][j];
            end
        end
`ifdef ALLOC_DEFLECT_EN
        free_port = port_avail;
        for (int j = 0; j < N; j++) begin
            for (int o = 0; o < N; o++) begin
                if (row_nxt[j][o]) free_port[o] = 1'b0;
            end
        end
        // Deflection grants bypass the arbiters, so they never move rr_ptr.
        for (int j = 0; j < N; j++) begin
            taken = |row_nxt[j];
            if (req_valid[j] && !taken) begin
                for (int o = 0; o < N; o++) begin
                    if (!taken && free_port[o]) begin
                        row_nxt[j][o] = 1'b1;
                        free_port[o]  = 1'b0;
                        taken         = 1'b1;
                    end
                end
            end
        end
`endif
    end

    always_comb begin
        vec_nxt = '0;
        gnt_nxt = '0;
        for (int j = 0; j < N; j++) begin
            vec_nxt[j*N +: N] = row_nxt[j];
            gnt_nxt[j]        = |row_nxt[j];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alloc_vector <= '0;
            grant        <= '0;
            alloc_valid  <= 1'b0;
            for (int o = 0; o < N; o++) rr_ptr[o] <= '0;
        end else begin
            alloc_vector <= vec_nxt;
            grant        <= gnt_nxt;
            alloc_valid  <= |gnt_nxt;
            for (int o = 0; o < N; o++) rr_ptr[o] <= rr_nxt[o];
        end
    end

endmodule

// File: tb/tb_port_alloc.sv
// Bench for port_alloc: directed vector table, contention/reset sequences, and random traffic vs a reference model.
module tb_port_alloc;

    logic        clk;
    logic        reset_n;
    logic [4:0]  req_valid;
    logic [24:0] req_port;
    logic [4:0]  port_avail;
    logic [24:0] alloc_vector;
    logic [4:0]  grant;
    logic        alloc_valid;

    int n_vec;
    int n_err;
    int mptr [5];
    logic [24:0] exp_vec;
    logic [4:0]  exp_gnt;

    typedef struct {
        logic [4:0]  v;
        logic [24:0] p;
        logic [4:0]  a;
        logic [24:0] ev;
        logic [4:0]  eg;
    } vec_t;

    vec_t tbl [8];

    port_alloc dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_port     (req_port),
        .port_avail   (port_avail),
        .alloc_vector (alloc_vector),
        .grant        (grant),
        .alloc_valid  (alloc_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] v, input logic [24:0] p, input logic [4:0] a,
                                input logic [24:0] ev, input logic [4:0] eg);
        vec_t r;
        r.v = v; r.p = p; r.a = a; r.ev = ev; r.eg = eg;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [24:0] act, input logic [24:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: pick highest usable port per input, then the requester closest
    // (cyclically) at or after each output's pointer wins.
    task automatic model(input logic [4:0] v, input logic [24:0] p, input logic [4:0] a,
                         output logic [24:0] ev, output logic [4:0] eg);
        int choice [5];
        int best, bestd, d;
        logic [24:0] r;
        logic [4:0]  used;
        bit done;
        r = '0;
        for (int j = 0; j < 5; j++) begin
            choice[j] = -1;
            if (v[j])
                for (int o = 4; o >= 0; o--)
                    if (choice[j] < 0 && p[j*5+o] && a[o]) choice[j] = o;
        end
        for (int o = 0; o < 5; o++) begin
            best = -1; bestd = 99;
            for (int i = 0; i < 5; i++) begin
                if (choice[i] == o) begin
                    d = (i - mptr[o] + 5) % 5;
                    if (d < bestd) begin bestd = d; best = i; end
                end
            end
            if (best >= 0) begin
                r[best*5+o] = 1'b1;
                mptr[o] = (best + 1) % 5;
            end
        end
`ifdef ALLOC_DEFLECT_EN
        used = '0;
        for (int j = 0; j < 5; j++)
            for (int o = 0; o < 5; o++)
                if (r[j*5+o]) used[o] = 1'b1;
        for (int j = 0; j < 5; j++) begin
            if (v[j] && r[j*5 +: 5] == 5'b0) begin
                done = 0;
                for (int o = 0; o < 5; o++) begin
                    if (!done && a[o] && !used[o]) begin
                        r[j*5+o] = 1'b1; used[o] = 1'b1; done = 1;
                    end
                end
            end
        end
`else
        used = '0;
        done = 0;
`endif
        ev = r;
        for (int j = 0; j < 5; j++) eg[j] = |r[j*5 +: 5];
    endtask

    task automatic apply(input logic [4:0] v, input logic [24:0] p, input logic [4:0] a);
        req_valid  = v;
        req_port   = p;
        port_avail = a;
        model(v, p, a, exp_vec, exp_gnt);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_vec"}, alloc_vector, 25'h0);
        chk({nm, "_grant"}, 25'(grant), 25'h0);
        chk({nm, "_valid"}, 25'(alloc_valid), 25'h0);
    endtask

    task automatic clr_model();
        for (int o = 0; o < 5; o++) mptr[o] = 0;
    endtask

    localparam logic [24:0] COL_N = 25'h0842108;
    localparam logic [24:0] CONT  = 25'h0000108;

    initial begin
        n_vec = 0;
        n_err = 0;
        clr_model();
        reset_n    = 1'b1;
        req_valid  = '0;
        req_port   = '0;
        port_avail = '0;

        tbl[0] = mk(5'b00100, 25'h0002000, 5'b11111, 25'h0002000, 5'b00100);
        tbl[1] = mk(5'b10000, 25'h1200000, 5'b11111, 25'h1000000, 5'b10000);
`ifdef ALLOC_DEFLECT_EN
        tbl[2] = mk(5'b00001, 25'h0000008, 5'b10111, 25'h0000001, 5'b00001);
        tbl[5] = mk(5'b00010, 25'h0000000, 5'b11111, 25'h0000020, 5'b00010);
        tbl[7] = mk(5'b11111, 25'h1FFFFFF, 5'b11111, 25'h0820830, 5'b11111);
`else
        tbl[2] = mk(5'b00001, 25'h0000008, 5'b10111, 25'h0000000, 5'b00000);
        tbl[5] = mk(5'b00010, 25'h0000000, 5'b11111, 25'h0000000, 5'b00000);
        tbl[7] = mk(5'b11111, 25'h1FFFFFF, 5'b11111, 25'h0000010, 5'b00001);
`endif
        tbl[3] = mk(5'b11111, 25'h1FFFFFF, 5'b00000, 25'h0000000, 5'b00000);
        tbl[4] = mk(5'b00000, 25'h1FFFFFF, 5'b11111, 25'h0000000, 5'b00000);
        tbl[6] = mk(5'b11111, 25'h1041041, 5'b11111, 25'h1041041, 5'b11111);

        // Reset held with random inputs: outputs stay zero, even across clock edges.
        #1;
        reset_n = 1'b0;
        req_valid  = 5'($urandom);
        req_port   = 25'($urandom);
        port_avail = 5'($urandom);
        #1;
        chk_zero("reset_async");
        for (int k = 0; k < 3; k++) begin
            req_valid  = 5'($urandom);
            req_port   = 25'($urandom);
            port_avail = 5'($urandom);
            @(posedge clk);
            #1;
            chk_zero("reset_held");
        end
        reset_n = 1'b1;
        clr_model();

        for (int t = 0; t < 8; t++) begin
            apply(tbl[t].v, tbl[t].p, tbl[t].a);
            chk($sformatf("tbl%0d_vec", t), alloc_vector, tbl[t].ev);
            chk($sformatf("tbl%0d_grant", t), 25'(grant), 25'(tbl[t].eg));
            chk($sformatf("tbl%0d_valid", t), 25'(alloc_valid), 25'(|tbl[t].eg));
        end

        for (int k = 0; k < 250; k++) begin
            apply(5'($urandom), 25'($urandom), 5'($urandom) | 5'($urandom));
            chk($sformatf("rand%0d_vec", k), alloc_vector, exp_vec);
            chk($sformatf("rand%0d_grant", k), 25'(grant), 25'(exp_gnt));
            chk($sformatf("rand%0d_valid", k), 25'(alloc_valid), 25'(|exp_gnt));
        end

        // Contention on N from reset: input 0, input 1, input 0.
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clr_model();
        apply(5'b00011, CONT, 5'b11111);
        chk("cont0_colN", alloc_vector & COL_N, 25'h0000008);
        apply(5'b00011, CONT, 5'b11111);
        chk("cont1_colN", alloc_vector & COL_N, 25'h0000100);
        apply(5'b00011, CONT, 5'b11111);
        chk("cont2_colN", alloc_vector & COL_N, 25'h0000008);
        chk("cont2_model", alloc_vector, exp_vec);

        // Reset in the middle of contention: clears at once, then restarts from input 0.
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clr_model();
        apply(5'b00011, CONT, 5'b11111);
        chk("mid0_colN", alloc_vector & COL_N, 25'h0000008);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("mid_async");
        @(posedge clk);
        #1;
        chk_zero("mid_held");
        reset_n = 1'b1;
        clr_model();
        apply(5'b00011, CONT, 5'b11111);
        chk("mid_release_colN", alloc_vector & COL_N, 25'h0000008);
        chk("mid_release_model", alloc_vector, exp_vec);
        apply(5'b00011, CONT, 5'b11111);
        chk("mid_next_colN", alloc_vector & COL_N, 25'h0000100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/port_alloc.md
# port_alloc

Registered switch allocator that produces the per-input one-hot allocation vector consumed by the crossbar control block. It sits between route computation and the crossbar. Each cycle it matches valid input flits to free output ports (W/E/S/N/Bypass) with per-output round-robin fairness. Its result drives the crossbar-select translation one cycle later.

## Interface
Parameters:
- `NUM_CHANNEL`, default `` `NUM_CHANNEL `` (5): number of input channels and output ports. Port indices: 4 Bypass, 3 N, 2 S, 1 E, 0 W.
- `LOG_NUM_PORT`, default `` `LOG_NUM_PORT `` (3): width of a port index and of a round-robin pointer.

Ports:
- `clk` in 1: sole clock. Everything is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_CHANNEL: input j holds a flit needing a port this cycle.
- `req_port` in NUM_CHANNEL*NUM_CHANNEL: row j at `[j*NUM_CHANNEL +: NUM_CHANNEL]` is input j's productive-port mask. It may be multi-hot.
- `port_avail` in NUM_CHANNEL: output o can accept a flit this cycle.
- `alloc_vector` out NUM_CHANNEL*NUM_CHANNEL: registered. Row j is one-hot (output port granted to input j) or zero.
- `grant` out NUM_CHANNEL: registered. `grant[j]` = OR of row j.
- `alloc_valid` out 1: registered. OR of `grant`.

## Operation
- Effective request: row j is `req_port` row j AND `port_avail`, and is zero when `req_valid[j]`=0.
- Stage 1 (input select): each input keeps exactly one bit of its effective request, chosen by fixed priority with the highest index winning (Bypass > N > S > E > W).
- Stage 2 (output arbitration): each output o has a round-robin arbiter over the inputs that selected it.
  - The search starts at `rr_ptr[o]` and wraps from NUM_CHANNEL-1 to 0.
  - The winner gets bit o in its row. Losers get nothing (separable allocator; no retry within the cycle).
- Pointer update: when output o grants input i, `rr_ptr[o]` <= i+1. If i+1 equals NUM_CHANNEL, the pointer becomes 0 (explicit compare, not power-of-two wrap). A pointer is unchanged when its output grants nothing.
- Invariants: at most one bit set per row and per column. A bit is never set for a port whose `port_avail` was 0 in the sampled cycle.
- Request with valid=1 and an all-zero mask: treated as no request. When `ALLOC_DEFLECT_EN` is defined, the deflection rule below applies instead.
- Inputs with no grant must re-present their request. No request state is stored inside the block.

## Timing
- One-cycle latency: inputs sampled at edge N appear on `alloc_vector`, `grant` and `alloc_valid` after edge N, and hold for exactly one cycle.
- Reset (`reset_n`=0) forces all outputs to 0 immediately (asynchronous) and all `rr_ptr` to 0.
- Release of `reset_n` mid-traffic: the first sampled edge allocates from pointer 0.
- Fully combinational path from inputs to the output registers. No input-to-output combinational path.
- All ports unavailable: all outputs are 0 on the next cycle. Pointers are unchanged.

## Configuration
- `ALLOC_DEFLECT_EN` defined (bufferless deflection):
  - After stage 2, every input with `req_valid` and no grant is assigned a free output, meaning one that is available and ungranted.
  - Unmatched inputs take free outputs in ascending index order, the lowest unmatched input taking the lowest free port.
  - Deflection grants do not update `rr_ptr`.
- Not defined: unmatched inputs get no grant.

## Structure
- Shared package (`global.v`) holds `NUM_CHANNEL`, `LOG_NUM_PORT` and the port-index constants (`PORT_W`=0 … `PORT_BYPASS`=4).
- Sub-module `rr_arbiter`, instantiated NUM_CHANNEL times (one per output):
  - inputs: request vector, pointer, enable;
  - outputs: one-hot grant and next pointer.
- Stage 1, the deflection logic, and the pointer and output registers live in `port_alloc`.

## Test plan
- Reset: hold `reset_n`=0 with random inputs. Required: `alloc_vector`=0, `grant`=0, `alloc_valid`=0 immediately.
- Single request: `req_valid`=5'b00100, row 2 = 5'b01000, `port_avail`=5'b11111. Required: next cycle row 2 = 5'b01000, `grant`=5'b00100, `alloc_valid`=1.
- Contention, 3 cycles: inputs 0 and 1 both request N (row = 5'b01000), all ports available, starting from reset. Required: grants go to input 0, then input 1, then input 0.
- Multi-hot request: input 4 row = 5'b10010, all ports available. Required: row 4 = 5'b10000.
- Unavailable port: input 0 requests only N with `port_avail`=5'b10111.
  - Without the macro: `grant`=0.
  - With `ALLOC_DEFLECT_EN`: row 0 = 5'b00001.
- Reset mid-contention: drop `reset_n` asynchronously in the middle of the 3-cycle scenario. Required: outputs clear immediately, and after release the first grant goes to input 0.
